// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encoding, the register-index width and the default
// parameter values. Both the top level and the hazard detector import it.
package pipeline_ctrl_pkg;

  localparam int REG_W = 4;

  localparam int DEF_FLUSH_CYCLES = 1;
  localparam int DEF_MEM_TIMEOUT  = 64;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational register-hazard detection.
// Ports:
//   i_Forwarding_Enable  forwarding mode requested
//   i_Src_1/i_Src_2      ID-stage source registers, i_Two_Src qualifies i_Src_2
//   i_Exe_*              EX-stage destination, write-back enable and load flag
//   i_Memory_*           MEM-stage destination and write-back enable
//   o_Hz_Exe/o_Hz_Mem    raw RAW matches against EX and MEM
//   o_Data_Stall         stall request for the ID stage
module hazard_detect_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic             i_Forwarding_Enable,
  input  logic [REG_W-1:0] i_Src_1,
  input  logic [REG_W-1:0] i_Src_2,
  input  logic             i_Two_Src,
  input  logic [REG_W-1:0] i_Exe_Destination,
  input  logic             i_Sig_Exe_Write_Back_Enable,
  input  logic             i_Sig_Exe_Memory_Read,
  input  logic [REG_W-1:0] i_Memory_Destination,
  input  logic             i_Sig_Memory_Write_Back_Enable,
  output logic             o_Hz_Exe,
  output logic             o_Hz_Mem,
  output logic             o_Data_Stall
);

  assign o_Hz_Exe = i_Sig_Exe_Write_Back_Enable &
                    ((i_Src_1 == i_Exe_Destination) |
                     (i_Two_Src & (i_Src_2 == i_Exe_Destination)));

  assign o_Hz_Mem = i_Sig_Memory_Write_Back_Enable &
                    ((i_Src_1 == i_Memory_Destination) |
                     (i_Two_Src & (i_Src_2 == i_Memory_Destination)));

  // With forwarding only a load result in EX cannot be bypassed in time.
  assign o_Data_Stall = i_Forwarding_Enable ? (o_Hz_Exe & i_Sig_Exe_Memory_Read)
                                            : (o_Hz_Exe | o_Hz_Mem);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Every cycle decides whether IF/ID/EX/MEM advance, freeze, take a bubble or
// get flushed, gates the forwarding enable and keeps stall/flush counters.
// Ports:
//   i_Clk, i_Rst_n           clock, asynchronous active-low reset
//   hazard inputs            forwarded to hazard_detect_unit
//   i_Branch_Taken           taken branch resolved in EX
//   i_Memory_Busy            data memory not ready
//   i_Clear_Counters         synchronous clear of the performance counters
//   o_Freeze_*, o_Bubble_*, o_Flush_IF_ID  pipeline control (same cycle)
//   o_Forwarding_Enable      effective forwarding enable
//   o_Mem_Timeout            sticky memory-timeout flag
//   o_State                  current FSM state
//   o_Stall_Count/o_Flush_Count  saturating counters
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Forwarding_Enable,
  input  logic [REG_W-1:0] i_Src_1,
  input  logic [REG_W-1:0] i_Src_2,
  input  logic             i_Two_Src,
  input  logic [REG_W-1:0] i_Exe_Destination,
  input  logic             i_Sig_Exe_Write_Back_Enable,
  input  logic             i_Sig_Exe_Memory_Read,
  input  logic [REG_W-1:0] i_Memory_Destination,
  input  logic             i_Sig_Memory_Write_Back_Enable,
  input  logic             i_Branch_Taken,
  input  logic             i_Memory_Busy,
  input  logic             i_Clear_Counters,
  output logic             o_Freeze_PC,
  output logic             o_Freeze_IF_ID,
  output logic             o_Bubble_ID_EX,
  output logic             o_Flush_IF_ID,
  output logic             o_Freeze_Back_End,
  output logic             o_Forwarding_Enable,
  output logic             o_Mem_Timeout,
  output logic [1:0]       o_State,
  output logic [CNT_W-1:0] o_Stall_Count,
  output logic [CNT_W-1:0] o_Flush_Count
);

  localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic hz_exe, hz_mem, data_stall;

  hazard_detect_unit u_hazard (
    .i_Forwarding_Enable           (i_Forwarding_Enable),
    .i_Src_1                       (i_Src_1),
    .i_Src_2                       (i_Src_2),
    .i_Two_Src                     (i_Two_Src),
    .i_Exe_Destination             (i_Exe_Destination),
    .i_Sig_Exe_Write_Back_Enable   (i_Sig_Exe_Write_Back_Enable),
    .i_Sig_Exe_Memory_Read         (i_Sig_Exe_Memory_Read),
    .i_Memory_Destination          (i_Memory_Destination),
    .i_Sig_Memory_Write_Back_Enable(i_Sig_Memory_Write_Back_Enable),
    .o_Hz_Exe                      (hz_exe),
    .o_Hz_Mem                      (hz_mem),
    .o_Data_Stall                  (data_stall)
  );

  state_e            state_q, state_d, ret_state_q, ret_state_d, eff_state;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_evt_q, flush_evt_d;
  logic              freeze_pc, freeze_if_id, bubble, flush, freeze_back, honour;

  always_comb begin
    // Releasing MEM_WAIT evaluates the cycle as the state it interrupted.
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT && !i_Memory_Busy) eff_state = ret_state_q;

    state_d      = state_q;
    ret_state_d  = ret_state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    bubble       = 1'b0;
    flush        = 1'b0;
    freeze_back  = 1'b0;
    honour       = 1'b0;

    if (i_Memory_Busy) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      freeze_back  = 1'b1;
      if (state_q != ST_MEM_WAIT) begin
        state_d     = ST_MEM_WAIT;
        ret_state_d = state_q;
        wait_cnt_d  = WAIT_W'(1);
      end else if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end else if ((eff_state == ST_RUN && i_Branch_Taken) || eff_state == ST_FLUSH) begin
      flush  = 1'b1;
      bubble = 1'b1;
      if (i_Branch_Taken) begin
        // A new branch (also inside FLUSH) restarts the flush window.
        honour      = 1'b1;
        flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - FC_W'(1);
        state_d     = (flush_cnt_q == FC_W'(1)) ? ST_RUN : ST_FLUSH;
      end
    end else begin
      state_d = ST_RUN;
      if (data_stall) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        bubble       = 1'b1;
      end
    end

    timeout_d = timeout_q | (i_Memory_Busy & (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)));

    stall_cnt_d = stall_cnt_q;
    if (i_Clear_Counters)                      stall_cnt_d = '0;
    else if (freeze_pc && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_evt_d = flush_evt_q;
    if (i_Clear_Counters)                      flush_evt_d = '0;
    else if (honour && flush_evt_q != '1)      flush_evt_d = flush_evt_q + CNT_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_RUN;
      ret_state_q <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_evt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_evt_q <= flush_evt_d;
    end
  end

  // Control outputs are combinational, so they are forced low during reset.
  assign o_Freeze_PC         = freeze_pc    & i_Rst_n;
  assign o_Freeze_IF_ID      = freeze_if_id & i_Rst_n;
  assign o_Bubble_ID_EX      = bubble       & i_Rst_n;
  assign o_Flush_IF_ID       = flush        & i_Rst_n;
  assign o_Freeze_Back_End   = freeze_back  & i_Rst_n;
  assign o_Forwarding_Enable = i_Forwarding_Enable & (state_q != ST_MEM_WAIT) & i_Rst_n;
  assign o_Mem_Timeout       = timeout_q;
  assign o_State             = state_q;
  assign o_Stall_Count       = stall_cnt_q;
  assign o_Flush_Count       = flush_evt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios followed by random
// traffic, all compared every cycle against a cycle-level behavioural model.
module tb_pipeline_hazard_controller;

  localparam int FC      = 3;
  localparam int MT      = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fwd, two, exe_wb, exe_rd, mem_wb, br, busy, clr;
  logic [3:0]    src1, src2, exe_dst, mem_dst;
  logic          f_pc, f_ifid, bub, fl, f_be, fwd_o, tmo;
  logic [1:0]    st;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: flush cycles still owed, whether last cycle was busy,
  // length of current busy run, sticky timeout, and the two counters.
  int m_pending, m_busy_run, m_stall, m_flush;
  bit m_prev_busy, m_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .i_Clk                         (clk),
    .i_Rst_n                       (rst_n),
    .i_Forwarding_Enable           (fwd),
    .i_Src_1                       (src1),
    .i_Src_2                       (src2),
    .i_Two_Src                     (two),
    .i_Exe_Destination             (exe_dst),
    .i_Sig_Exe_Write_Back_Enable   (exe_wb),
    .i_Sig_Exe_Memory_Read         (exe_rd),
    .i_Memory_Destination          (mem_dst),
    .i_Sig_Memory_Write_Back_Enable(mem_wb),
    .i_Branch_Taken                (br),
    .i_Memory_Busy                 (busy),
    .i_Clear_Counters              (clr),
    .o_Freeze_PC                   (f_pc),
    .o_Freeze_IF_ID                (f_ifid),
    .o_Bubble_ID_EX                (bub),
    .o_Flush_IF_ID                 (fl),
    .o_Freeze_Back_End             (f_be),
    .o_Forwarding_Enable           (fwd_o),
    .o_Mem_Timeout                 (tmo),
    .o_State                       (st),
    .o_Stall_Count                 (stall_cnt),
    .o_Flush_Count                 (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending   = 0;
    m_busy_run  = 0;
    m_stall     = 0;
    m_flush     = 0;
    m_prev_busy = 0;
    m_timeout   = 0;
  endtask

  task automatic idle();
    fwd = 1'b1; two = 1'b0; exe_wb = 1'b0; exe_rd = 1'b0; mem_wb = 1'b0;
    br = 1'b0; busy = 1'b0; clr = 1'b0;
    src1 = 4'd0; src2 = 4'd0; exe_dst = 4'd0; mem_dst = 4'd0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit hz_e, hz_m, ds, e_fpc, e_fif, e_bub, e_fl, e_fbe, e_fwd, hon;
    int e_state;
    @(negedge clk);
    e_fpc = 0; e_fif = 0; e_bub = 0; e_fl = 0; e_fbe = 0; hon = 0;
    if (!rst_n) begin
      model_reset();
      e_state = 0;
      e_fwd   = 0;
    end else begin
      hz_e = exe_wb && (src1 == exe_dst || (two && src2 == exe_dst));
      hz_m = mem_wb && (src1 == mem_dst || (two && src2 == mem_dst));
      ds   = fwd ? (hz_e && exe_rd) : (hz_e || hz_m);
      e_state = m_prev_busy ? 1 : (m_pending > 0 ? 2 : 0);
      e_fwd   = fwd && !m_prev_busy;
      if (busy) begin
        e_fpc = 1; e_fif = 1; e_fbe = 1;
      end else if (br) begin
        e_fl = 1; e_bub = 1; hon = 1;
      end else if (m_pending > 0) begin
        e_fl = 1; e_bub = 1;
      end else if (ds) begin
        e_fpc = 1; e_fif = 1; e_bub = 1;
      end
    end
    chk("freeze_pc",   32'(f_pc),      32'(e_fpc));
    chk("freeze_ifid", 32'(f_ifid),    32'(e_fif));
    chk("bubble",      32'(bub),       32'(e_bub));
    chk("flush",       32'(fl),        32'(e_fl));
    chk("freeze_be",   32'(f_be),      32'(e_fbe));
    chk("fwd_en",      32'(fwd_o),     32'(e_fwd));
    chk("state",       32'(st),        32'(e_state));
    chk("timeout",     32'(tmo),       32'(m_timeout));
    chk("stall_cnt",   32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt",   32'(flush_cnt), 32'(m_flush));
    @(posedge clk);
    if (rst_n) begin
      if (!busy) begin
        if (hon) m_pending = FC - 1;
        else if (m_pending > 0) m_pending--;
      end
      m_prev_busy = busy;
      m_busy_run  = busy ? ((m_busy_run < MT) ? m_busy_run + 1 : MT) : 0;
      if (m_busy_run >= MT) m_timeout = 1;
      m_stall = clr ? 0 : ((e_fpc && m_stall < CNT_MAX) ? m_stall + 1 : m_stall);
      m_flush = clr ? 0 : ((hon && m_flush < CNT_MAX) ? m_flush + 1 : m_flush);
    end
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Load-use with forwarding: one-cycle stall; without load: none.
    src1 = 4'd3; exe_dst = 4'd3; exe_wb = 1'b1; exe_rd = 1'b1;
    cycle();
    exe_rd = 1'b0;
    cycle();
    idle();

    // No forwarding: MEM-stage match on Src_2 counts only with Two_Src.
    fwd = 1'b0; src1 = 4'd1; src2 = 4'd5; two = 1'b1; mem_dst = 4'd5; mem_wb = 1'b1;
    cycle();
    two = 1'b0;
    cycle();
    idle();

    // Branch: three flush cycles.
    br = 1'b1;
    cycle();
    br = 1'b0;
    repeat (3) cycle();

    // Memory wait in the middle of a flush window.
    br = 1'b1;
    cycle();
    br = 1'b0;
    cycle();
    busy = 1'b1;
    repeat (4) cycle();
    busy = 1'b0;
    repeat (3) cycle();

    // Timeout: busy for 10 cycles, flag stays after release.
    busy = 1'b1;
    repeat (10) cycle();
    busy = 1'b0;
    repeat (2) cycle();

    // Reset in the middle of MEM_WAIT: outputs drop immediately.
    busy = 1'b1; fwd = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_freeze_pc", 32'(f_pc),  32'd0);
    chk("rst_freeze_be", 32'(f_be),  32'd0);
    chk("rst_fwd_en",    32'(fwd_o), 32'd0);
    chk("rst_state",     32'(st),    32'd0);
    chk("rst_timeout",   32'(tmo),   32'd0);
    cycle();
    busy = 1'b0;
    rst_n = 1'b1;
    cycle();

    // Clear wins over a concurrent stall increment.
    src1 = 4'd3; exe_dst = 4'd3; exe_wb = 1'b1; exe_rd = 1'b1;
    cycle();
    clr = 1'b1;
    cycle();
    idle();
    // Saturate the stall counter and hold at all-ones.
    busy = 1'b1;
    repeat (CNT_MAX + 4) cycle();
    busy = 1'b0;
    repeat (2) cycle();

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      fwd     = ($urandom_range(0, 3) != 0);
      src1    = 4'($urandom_range(0, 3));
      src2    = 4'($urandom_range(0, 3));
      two     = 1'($urandom_range(0, 1));
      exe_dst = 4'($urandom_range(0, 3));
      mem_dst = 4'($urandom_range(0, 3));
      exe_wb  = 1'($urandom_range(0, 1));
      exe_rd  = 1'($urandom_range(0, 1));
      mem_wb  = 1'($urandom_range(0, 1));
      br      = ($urandom_range(0, 6) == 0);
      busy    = (i % 97 > 80) || ($urandom_range(0, 5) == 0);
      clr     = ($urandom_range(0, 40) == 0);
      rst_n   = ($urandom_range(0, 150) != 0);
      cycle();
    end
    idle();
    rst_n = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
